// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : request FIFO + IDLE/ISSUE/RESP sequencer for MemoryUnit.
// Optional: MEM_ACC_ALIGN_CHK_EN rejects non-word-aligned requests with error.
// Rev 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic                  busy_o
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(MEM_RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_we;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    state_t                r_state;
    logic                  r_cmd_we;
    logic [c_LAT_W-1:0]    r_lat_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_we;
    logic [DATA_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_wdata;
    logic                  w_head_misaligned;

    // Ready looks at full only, so a same-cycle pop never frees a slot early.
    assign req_ready_o  = (r_count != c_FULL);
    assign w_push       = req_valid_i && req_ready_o;
    assign w_pop        = (r_state == ST_IDLE) && (r_count != '0);
    assign busy_o       = (r_state != ST_IDLE) || (r_count != '0);

    assign w_head_we    = r_fifo_we[r_rd_ptr];
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr];

`ifdef MEM_ACC_ALIGN_CHK_EN
    assign w_head_misaligned = (w_head_addr[1:0] != 2'b00);
`else
    assign w_head_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]    <= req_we_i;
            r_fifo_addr[r_wr_ptr]  <= req_addr_i;
            r_fifo_wdata[r_wr_ptr] <= req_wdata_i;
        end
    end

    // The memory-port registers double as the command register; they keep
    // their value outside ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_we    <= 1'b0;
            r_lat_cnt   <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wd_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        if (w_head_misaligned) begin
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= '0;
                            rsp_err_o   <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_cmd_we   <= w_head_we;
                            mem_we_o   <= w_head_we;
                            mem_addr_o <= w_head_addr;
                            mem_wd_o   <= w_head_wdata;
                            r_lat_cnt  <= '0;
                            r_state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_cmd_we) begin
                        mem_we_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (r_lat_cnt == c_LAT_LAST) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= mem_rd_i;
                        rsp_err_o   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_access_ctrl : randomized + directed bench with a transaction-timeline
// reference model and a behavioural memory behind the memory port.
// Rev 1.0
// ============================================================================
module tb_mem_access_ctrl;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we    = 1'b0;
    logic [DW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_rd    = '0;
    logic          busy;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .MEM_RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_we_o    (mem_we),
        .mem_wd_o    (mem_wd),
        .mem_addr_o  (mem_addr),
        .mem_rd_i    (mem_rd),
        .busy_o      (busy)
    );

    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    req_t          fifo_q[$];
    logic [DW-1:0] ref_mem  [logic [DW-1:0]];
    logic [DW-1:0] phys_mem [logic [DW-1:0]];

    function automatic logic [DW-1:0] mem_default(input logic [DW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] phys_lookup(input logic [DW-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : mem_default(a);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each popped request gets a timeline (pop cycle, first
    // response cycle); outputs are derived from where the cycle falls in it.
    bit            checking      = 0;
    bit            act_valid     = 0;
    bit            act_issue     = 0;
    bit            act_we        = 0;
    logic          act_err       = 1'b0;
    int            act_rsp_start = 0;
    logic [DW-1:0] act_rdata     = '0;
    logic [DW-1:0] last_addr     = '0;
    logic [DW-1:0] last_wd       = '0;
    logic [DW-1:0] last_rd       = '0;
    logic          last_err      = 1'b0;

    always @(negedge clk) begin : model
        bit   in_issue;
        bit   in_resp;
        bit   exp_ready;
        bit   mis;
        req_t h;
        req_t nr;
        in_issue  = act_valid && act_issue && (cyc < act_rsp_start);
        in_resp   = act_valid && (cyc >= act_rsp_start);
        exp_ready = (fifo_q.size() < DEPTH);
        if (in_resp) begin
            last_rd  = act_rdata;
            last_err = act_err;
        end
        if (checking) begin
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, act_valid || (fifo_q.size() != 0));
            chk("mem_we", mem_we, in_issue && act_we);
            chk("mem_addr", mem_addr, last_addr);
            chk("mem_wd", mem_wd, last_wd);
            chk("rsp_valid", rsp_valid, in_resp);
            chk("rsp_rdata", rsp_rdata, last_rd);
            chk("rsp_err", rsp_err, last_err);
        end
        // Memory returns valid data only in the cycle the read must be sampled.
        if (in_issue && !act_we && (cyc == act_rsp_start - 1))
            mem_rd = phys_lookup(mem_addr);
        else
            mem_rd = $urandom;
        if (mem_we === 1'b1)
            phys_mem[mem_addr] = mem_wd;

        if (rst) begin
            fifo_q.delete();
            act_valid = 0;
            last_addr = '0;
            last_wd   = '0;
            last_rd   = '0;
            last_err  = 1'b0;
            checking  = 1;
        end else begin
            if (!act_valid && (fifo_q.size() != 0)) begin
                h = fifo_q.pop_front();
                act_valid = 1;
`ifdef MEM_ACC_ALIGN_CHK_EN
                mis = (h.addr[1:0] != 2'b00);
`else
                mis = 0;
`endif
                if (mis) begin
                    act_issue     = 0;
                    act_we        = 0;
                    act_rsp_start = cyc + 1;
                    act_rdata     = '0;
                    act_err       = 1'b1;
                end else begin
                    act_issue     = 1;
                    act_we        = h.we;
                    act_err       = 1'b0;
                    last_addr     = h.addr;
                    last_wd       = h.wdata;
                    act_rsp_start = cyc + 1 + (h.we ? 1 : RD_LAT);
                    if (h.we) begin
                        ref_mem[h.addr] = h.wdata;
                        act_rdata = '0;
                    end else begin
                        act_rdata = ref_mem.exists(h.addr) ? ref_mem[h.addr] : mem_default(h.addr);
                    end
                end
            end else if (in_resp && rsp_ready) begin
                act_valid = 0;
            end
            if (req_valid && exp_ready) begin
                nr.we    = req_we;
                nr.addr  = req_addr;
                nr.wdata = req_wdata;
                fifo_q.push_back(nr);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout: req_ready stayed %0b for %0d cycles, expected 1", req_ready, n);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b rsp_valid=%0b after %0d cycles, expected 0", busy, rsp_valid, n);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);

        // Write then read back; read response lands 2+RD_LAT cycles after accept.
        rsp_ready = 1'b1;
        send(1'b1, 32'h10, 32'hCAFE_0001);
        wait_idle();
        chk("t1_mem_written", phys_lookup(32'h10), 32'hCAFE_0001);
        send(1'b0, 32'h10, 32'h0);
        repeat (RD_LAT) tick();
        chk("t1_rsp_not_yet", rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("t1_err", rsp_err, 0);
        wait_idle();

        // Backpressure: one in flight plus a full FIFO, then a held response.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(1'(i % 2), 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        chk("t2_full_not_ready", req_ready, 0);
        repeat (4) tick();
        chk("t3_rsp_held", rsp_valid, 1);
        chk("t3_no_we", mem_we, 0);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset with three queued and one waiting in RESP.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(1'b1, 32'h80 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        repeat (3) tick();
        chk("t5_pre_rsp_valid", rsp_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_wd", mem_wd, 0);
        chk("t5_rdata", rsp_rdata, 0);
        chk("t5_busy", busy, 0);
        chk("t5_req_ready", req_ready, 1);
        rsp_ready = 1'b1;
        repeat (5) tick();
        chk("t5_no_rsp", rsp_valid, 0);

        // Misaligned write.
        send(1'b1, 32'h13, 32'h1234_5678);
`ifdef MEM_ACC_ALIGN_CHK_EN
        tick();
        chk("t6_err", rsp_err, 1);
        wait_idle();
        chk("t6_no_write", phys_mem.exists(32'h13), 0);
`else
        repeat (2) tick();
        chk("t6_err", rsp_err, 0);
        wait_idle();
        chk("t6_write", phys_lookup(32'h13), 32'h1234_5678);
`endif

        // Randomized traffic with occasional resets and misaligned addresses.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 32'h100 + 32'(4 * $urandom_range(0, 7))
                      + (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
